// File: rtl/fsk_modulator_if.sv
`default_nettype none
// ============================================================================
// Module      : fsk_modulator_if
// Description : Byte transmit handshake between a byte source and the FSK
//               modulator.
//               tx_data  - byte to transmit, sampled on accept
//               tx_valid - tx_data is valid
//               tx_ready - modulator can accept a byte
//               master : byte source (drives tx_data / tx_valid)
//               slave  : modulator   (drives tx_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface fsk_modulator_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/fsk_modulator.sv
`default_nettype none
// ============================================================================
// Module      : fsk_modulator
// Description : Binary FSK transmitter. Frames each accepted byte as start
//               bit, 8 data bits LSB first, stop bit; each bit lasts BAUD_DIV
//               clocks. Bits are sent as a phase-continuous square wave:
//               mark tone (half-period HALF_MARK) for '1', space tone
//               (half-period HALF_SPACE) for '0'. Idles at the mark tone.
//               HALF_MARK, HALF_SPACE and BAUD_DIV must each be >= 2.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-high reset
//               tx       - byte handshake (slave side)
//               fsk_out  - modulated square wave
//               tone_sel - current tone, 1 = mark, 0 = space
//               busy     - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_modulator #(
    parameter int unsigned HALF_MARK  = 98,
    parameter int unsigned HALF_SPACE = 99,
    parameter int unsigned BAUD_DIV   = 1000
) (
    input  logic           clk,
    input  logic           rst,
    fsk_modulator_if.slave tx,
    output logic           fsk_out,
    output logic           tone_sel,
    output logic           busy
);

    localparam logic [31:0] c_HALF_MARK  = 32'(HALF_MARK);
    localparam logic [31:0] c_HALF_SPACE = 32'(HALF_SPACE);
    localparam logic [31:0] c_BAUD_LAST  = 32'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_baud_cnt;
    logic [31:0] r_bit_idx;
    logic [7:0]  r_shift;
    logic [31:0] r_tone_cnt;
    logic        r_fsk_out;

    logic        w_ready;
    logic        w_accept;
    logic        w_bit_end;
    logic        w_tone_sel;
    logic [31:0] w_lim;
    logic        w_toggle;

    // Handshake and tone selection are decoded straight from the state
    // register so they change in the same cycle as the state itself.
    assign w_ready   = (r_state == S_IDLE);
    assign w_accept  = tx.tx_valid && w_ready;
    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    always_comb begin
        w_tone_sel = 1'b1;
        case (r_state)
            S_IDLE:  w_tone_sel = 1'b1;
            S_START: w_tone_sel = 1'b0;
            S_DATA:  w_tone_sel = r_shift[0];
            S_STOP:  w_tone_sel = 1'b1;
            default: w_tone_sel = 1'b1;
        endcase
    end

    // Framing FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= tx.tx_data;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_bit_idx  <= r_bit_idx + 32'd1;
                        if (r_bit_idx == 32'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 32'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tone generator. The limit follows the tone selected this cycle, but the
    // count itself is only cleared on a toggle, so a tone change stretches or
    // shrinks the half-period in progress instead of restarting it. That
    // keeps the waveform phase-continuous across bit boundaries.
    assign w_lim    = w_tone_sel ? c_HALF_MARK : c_HALF_SPACE;
    assign w_toggle = (r_tone_cnt >= (w_lim - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tone_cnt <= '0;
            r_fsk_out  <= 1'b0;
        end else if (w_toggle) begin
            r_tone_cnt <= '0;
            r_fsk_out  <= ~r_fsk_out;
        end else begin
            r_tone_cnt <= r_tone_cnt + 32'd1;
        end
    end

    assign tx.tx_ready = w_ready;
    assign busy        = ~w_ready;
    assign tone_sel    = w_tone_sel;
    assign fsk_out     = r_fsk_out;

endmodule
`default_nettype wire

// File: tb/tb_fsk_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsk_modulator
// Description : Self-checking bench for fsk_modulator. Two instances: one
//               with default parameters, one with HALF_MARK=2, HALF_SPACE=5,
//               BAUD_DIV=20. A frame-level reference model (list of accepted
//               frames -> expected tone per cycle) drives per-cycle monitors
//               that score tone_sel, busy, tx_ready and every fsk_out
//               half-period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsk_modulator;

    localparam longint B1  = 1000;
    localparam int     HM1 = 98;
    localparam int     HS1 = 99;
    localparam longint B2  = 20;
    localparam int     HM2 = 2;
    localparam int     HS2 = 5;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    fsk_modulator_if if1 ();
    fsk_modulator_if if2 ();
    logic fsk1, tone1, busy1;
    logic fsk2, tone2, busy2;

    fsk_modulator dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx       (if1.slave),
        .fsk_out  (fsk1),
        .tone_sel (tone1),
        .busy     (busy1)
    );

    fsk_modulator #(
        .HALF_MARK  (HM2),
        .HALF_SPACE (HS2),
        .BAUD_DIV   (20)
    ) dut2 (
        .clk      (clk),
        .rst      (rst),
        .tx       (if2.slave),
        .fsk_out  (fsk2),
        .tone_sel (tone2),
        .busy     (busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: accepted frames (accept edge, byte) per instance.
    longint     fr_n[$];
    logic [7:0] fr_d[$];
    longint     fr2_n[$];
    logic [7:0] fr2_d[$];

    // Expected tone in the cycle after edge e: frame bit k = (e-n)/BAUD,
    // bits are {stop=1, data[7:0], start=0} indexed from the start bit.
    function automatic bit model_tone(input longint e, input bit which);
        bit         t;
        logic [9:0] bits;
        longint     n;
        longint     b;
        int         cnt;
        t   = 1'b1;
        b   = which ? B2 : B1;
        cnt = which ? fr2_n.size() : fr_n.size();
        for (int i = 0; i < cnt; i++) begin
            n = which ? fr2_n[i] : fr_n[i];
            if (e >= n && e < n + 10 * b) begin
                bits = {1'b1, (which ? fr2_d[i] : fr_d[i]), 1'b0};
                t    = bits[int'((e - n) / b)];
            end
        end
        return t;
    endfunction

    function automatic bit model_busy(input longint e, input bit which);
        bit     bz;
        longint n;
        longint b;
        int     cnt;
        bz  = 1'b0;
        b   = which ? B2 : B1;
        cnt = which ? fr2_n.size() : fr_n.size();
        for (int i = 0; i < cnt; i++) begin
            n = which ? fr2_n[i] : fr_n[i];
            if (e >= n && e < n + 10 * b) bz = 1'b1;
        end
        return bz;
    endfunction

    // Allowed length of a half-period that ends with a toggle at edge t1 and
    // began with a toggle at edge t0: the toggle decisions at edges t0+1..t1
    // see the tones of cycles t0..t1-1. One tone throughout -> exact length,
    // a tone change inside -> anywhere between the two half-periods.
    function automatic void half_range(input longint t0, input longint t1, input bit which,
                                       output int lo, output int hi);
        bit first;
        bit mixed;
        int hm;
        int hs;
        hm    = which ? HM2 : HM1;
        hs    = which ? HS2 : HS1;
        first = model_tone(t0, which);
        mixed = 1'b0;
        for (longint j = t0 + 1; j < t1; j++) begin
            if (model_tone(j, which) != first) mixed = 1'b1;
        end
        if (mixed) begin
            lo = (hm < hs) ? hm : hs;
            hi = (hm < hs) ? hs : hm;
        end else begin
            lo = first ? hm : hs;
            hi = lo;
        end
    endfunction

    // Per-cycle scoreboards, sampled on the falling edge.
    bit     m1_en = 1'b0, m1_have = 1'b0;
    logic   m1_prev;
    longint m1_last, m1_bad_at;
    int     m1_bad_tone, m1_bad_busy, m1_bad_rdy, m1_bad_half, m1_n_half;
    int     m1_busy_cnt, m1_min, m1_max, m1_bad_len;

    bit     m2_en = 1'b0, m2_have = 1'b0;
    logic   m2_prev;
    longint m2_last;
    int     m2_bad_tone, m2_bad_busy, m2_bad_half, m2_n_half;
    int     m2_busy_cnt, m2_min, m2_max;

    longint acc_q[$];

    always @(negedge clk) begin
        int  lo, hi;
        longint len;
        if (m1_en) begin
            if (tone1 !== model_tone(cyc, 1'b0)) m1_bad_tone++;
            if (busy1 !== model_busy(cyc, 1'b0)) m1_bad_busy++;
            if (if1.tx_ready !== !model_busy(cyc, 1'b0)) m1_bad_rdy++;
            if (busy1 === 1'b1) m1_busy_cnt++;
            if (fsk1 !== m1_prev) begin
                if (m1_have) begin
                    len = cyc - m1_last;
                    half_range(m1_last, cyc, 1'b0, lo, hi);
                    if (len < lo || len > hi) begin
                        m1_bad_half++;
                        m1_bad_len = int'(len);
                        m1_bad_at  = cyc;
                    end
                    if (len < m1_min) m1_min = int'(len);
                    if (len > m1_max) m1_max = int'(len);
                    m1_n_half++;
                end
                m1_have = 1'b1;
                m1_last = cyc;
            end
            m1_prev = fsk1;
        end
        if (m2_en) begin
            if (tone2 !== model_tone(cyc, 1'b1)) m2_bad_tone++;
            if (busy2 !== model_busy(cyc, 1'b1)) m2_bad_busy++;
            if (busy2 === 1'b1) m2_busy_cnt++;
            if (fsk2 !== m2_prev) begin
                if (m2_have) begin
                    len = cyc - m2_last;
                    half_range(m2_last, cyc, 1'b1, lo, hi);
                    if (len < lo || len > hi) m2_bad_half++;
                    if (len < m2_min) m2_min = int'(len);
                    if (len > m2_max) m2_max = int'(len);
                    m2_n_half++;
                end
                m2_have = 1'b1;
                m2_last = cyc;
            end
            m2_prev = fsk2;
        end
        if (if1.tx_valid && if1.tx_ready === 1'b1 && !rst) acc_q.push_back(cyc + 1);
    end

    task automatic mon1_start();
        m1_bad_tone = 0; m1_bad_busy = 0; m1_bad_rdy = 0; m1_bad_half = 0;
        m1_n_half = 0; m1_busy_cnt = 0; m1_min = 1 << 30; m1_max = 0;
        m1_bad_len = 0; m1_bad_at = 0;
        m1_have = 1'b0; m1_prev = fsk1; m1_en = 1'b1;
    endtask

    task automatic mon2_start();
        m2_bad_tone = 0; m2_bad_busy = 0; m2_bad_half = 0; m2_n_half = 0;
        m2_busy_cnt = 0; m2_min = 1 << 30; m2_max = 0;
        m2_have = 1'b0; m2_prev = fsk2; m2_en = 1'b1;
    endtask

    // Advance to #1 after edge t.
    task automatic wait_edge(input longint t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called from #1 after an edge with dut1 idle; accept is the next edge.
    task automatic send1(input logic [7:0] d, output longint n);
        if1.tx_data  = d;
        if1.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        if1.tx_valid = 1'b0;
        if1.tx_data  = ~d;
        fr_n.push_back(n);
        fr_d.push_back(d);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (fsk1 !== 1'b0)  begin n_bad++; $display("FAIL reset_fsk: got %b want 0", fsk1); end
        n_cmp++; if (tone1 !== 1'b1) begin n_bad++; $display("FAIL reset_tone: got %b want 1", tone1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
        n_cmp++; if (if1.tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", if1.tx_ready); end
        n_cmp++; if ({fsk2, tone2, busy2, if2.tx_ready} !== 4'b0101) begin
            n_bad++; $display("FAIL reset_dut2: got %b want 0101", {fsk2, tone2, busy2, if2.tx_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_idle_tone();
        fr_n.delete(); fr_d.delete();
        mon1_start();
        repeat (2000) @(posedge clk);
        #1;
        m1_en = 1'b0;
        n_cmp++; if (m1_bad_tone !== 0) begin n_bad++; $display("FAIL idle_tone: %0d bad cycles, want 0", m1_bad_tone); end
        n_cmp++; if (m1_bad_busy !== 0) begin n_bad++; $display("FAIL idle_busy: %0d bad cycles, want 0", m1_bad_busy); end
        n_cmp++; if (m1_bad_rdy !== 0)  begin n_bad++; $display("FAIL idle_ready: %0d bad cycles, want 0", m1_bad_rdy); end
        n_cmp++; if (m1_bad_half !== 0) begin n_bad++; $display("FAIL idle_half: %0d bad, len %0d at %0d, want all 98", m1_bad_half, m1_bad_len, m1_bad_at); end
        n_cmp++; if (m1_n_half < 19)    begin n_bad++; $display("FAIL idle_count: %0d half-periods, want >= 19", m1_n_half); end
    endtask

    task automatic test_single_frame();
        longint    n;
        logic [0:9] seq;
        seq = 10'b0101001011;
        repeat (7) @(posedge clk);
        #1;
        fr_n.delete(); fr_d.delete();
        mon1_start();
        send1(8'hA5, n);
        for (int k = 0; k < 10; k++) begin
            wait_edge(n + k * B1 + B1 / 2);
            n_cmp++;
            if (tone1 !== seq[k]) begin n_bad++; $display("FAIL a5_bit%0d: tone_sel %b want %b", k, tone1, seq[k]); end
        end
        wait_edge(n + 10 * B1 + 5);
        m1_en = 1'b0;
        n_cmp++; if (m1_bad_tone !== 0) begin n_bad++; $display("FAIL a5_tone: %0d bad cycles, want 0", m1_bad_tone); end
        n_cmp++; if (m1_bad_busy !== 0) begin n_bad++; $display("FAIL a5_busy: %0d bad cycles, want 0", m1_bad_busy); end
        n_cmp++; if (m1_bad_half !== 0) begin n_bad++; $display("FAIL a5_half: %0d bad, len %0d at %0d, want 0", m1_bad_half, m1_bad_len, m1_bad_at); end
        n_cmp++; if (m1_busy_cnt !== 10000) begin n_bad++; $display("FAIL a5_busy_len: %0d clocks, want 10000", m1_busy_cnt); end
        n_cmp++; if (m1_min !== 98 || m1_max !== 99) begin n_bad++; $display("FAIL a5_minmax: %0d..%0d, want 98..99", m1_min, m1_max); end
    endtask

    task automatic test_handshake();
        longint n1, n2, a0, a1;
        fr_n.delete(); fr_d.delete(); acc_q.delete();
        mon1_start();
        if1.tx_data  = 8'h00;
        if1.tx_valid = 1'b1;
        n1 = cyc + 1;
        fr_n.push_back(n1); fr_d.push_back(8'h00);
        wait_edge(n1 + 5000);
        if1.tx_data = 8'hFF;
        n2 = n1 + 10 * B1 + 1;
        fr_n.push_back(n2); fr_d.push_back(8'hFF);
        wait_edge(n2);
        if1.tx_valid = 1'b0;
        if1.tx_data  = 8'h00;
        wait_edge(n2 + 10 * B1 + 5);
        m1_en = 1'b0;
        a0 = (acc_q.size() > 0) ? acc_q[0] : -1;
        a1 = (acc_q.size() > 1) ? acc_q[1] : -1;
        n_cmp++; if (acc_q.size() !== 2) begin n_bad++; $display("FAIL hs_accepts: %0d accepts, want 2", acc_q.size()); end
        n_cmp++; if (a0 !== n1) begin n_bad++; $display("FAIL hs_accept0: edge %0d want %0d", a0, n1); end
        n_cmp++; if (a1 !== n2) begin n_bad++; $display("FAIL hs_accept1: edge %0d want %0d", a1, n2); end
        n_cmp++; if (m1_bad_tone !== 0) begin n_bad++; $display("FAIL hs_tone: %0d bad cycles, want 0", m1_bad_tone); end
        n_cmp++; if (m1_bad_rdy !== 0)  begin n_bad++; $display("FAIL hs_ready: %0d bad cycles, want 0", m1_bad_rdy); end
        n_cmp++; if (m1_bad_busy !== 0) begin n_bad++; $display("FAIL hs_busy: %0d bad cycles, want 0", m1_bad_busy); end
        n_cmp++; if (m1_bad_half !== 0) begin n_bad++; $display("FAIL hs_half: %0d bad, len %0d at %0d, want 0", m1_bad_half, m1_bad_len, m1_bad_at); end
    endtask

    task automatic test_phase_continuity();
        longint n;
        repeat (3) @(posedge clk);
        #1;
        fr_n.delete(); fr_d.delete();
        mon1_start();
        send1(8'h55, n);
        wait_edge(n + 10 * B1 + 5);
        m1_en = 1'b0;
        n_cmp++; if (m1_bad_half !== 0) begin n_bad++; $display("FAIL pc_half: %0d bad, len %0d at %0d, want 0", m1_bad_half, m1_bad_len, m1_bad_at); end
        n_cmp++; if (m1_min < 98 || m1_max > 99) begin n_bad++; $display("FAIL pc_minmax: %0d..%0d, want within 98..99", m1_min, m1_max); end
        n_cmp++; if (m1_n_half < 95) begin n_bad++; $display("FAIL pc_count: %0d half-periods, want >= 95", m1_n_half); end
        n_cmp++; if (m1_bad_tone !== 0) begin n_bad++; $display("FAIL pc_tone: %0d bad cycles, want 0", m1_bad_tone); end
    endtask

    task automatic test_back_to_back();
        longint     na, nb, a1;
        logic [7:0] d1, d2;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        repeat ($urandom_range(1, 40)) @(posedge clk);
        #1;
        fr_n.delete(); fr_d.delete(); acc_q.delete();
        mon1_start();
        send1(d1, na);
        wait_edge(na + 10 * B1);
        send1(d2, nb);
        wait_edge(nb + 10 * B1 + 5);
        m1_en = 1'b0;
        a1 = (acc_q.size() > 1) ? acc_q[1] : -1;
        n_cmp++; if (a1 !== na + 10 * B1 + 1) begin n_bad++; $display("FAIL b2b_accept: edge %0d want %0d", a1, na + 10 * B1 + 1); end
        n_cmp++; if (m1_bad_tone !== 0) begin n_bad++; $display("FAIL b2b_tone: %0d bad cycles (data %h %h), want 0", m1_bad_tone, d1, d2); end
        n_cmp++; if (m1_bad_busy !== 0) begin n_bad++; $display("FAIL b2b_busy: %0d bad cycles, want 0", m1_bad_busy); end
        n_cmp++; if (m1_bad_half !== 0) begin n_bad++; $display("FAIL b2b_half: %0d bad, len %0d at %0d, want 0", m1_bad_half, m1_bad_len, m1_bad_at); end
        n_cmp++; if (m1_busy_cnt !== 20000) begin n_bad++; $display("FAIL b2b_busy_len: %0d clocks, want 20000", m1_busy_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        longint n;
        repeat (5) @(posedge clk);
        #1;
        fr_n.delete(); fr_d.delete();
        send1(8'h3C, n);
        wait_edge(n + 4 * B1 + B1 / 2);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (fsk1 !== 1'b0)  begin n_bad++; $display("FAIL rmf_fsk: got %b want 0", fsk1); end
        n_cmp++; if (tone1 !== 1'b1) begin n_bad++; $display("FAIL rmf_tone: got %b want 1", tone1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rmf_busy: got %b want 0", busy1); end
        n_cmp++; if (if1.tx_ready !== 1'b1) begin n_bad++; $display("FAIL rmf_ready: got %b want 1", if1.tx_ready); end
        repeat (3) @(posedge clk);
        #1;
        fr_n.delete(); fr_d.delete(); acc_q.delete();
        // Valid rises together with reset release; accept is the next edge.
        rst          = 1'b0;
        if1.tx_data  = 8'h81;
        if1.tx_valid = 1'b1;
        n = cyc + 1;
        fr_n.push_back(n); fr_d.push_back(8'h81);
        mon1_start();
        @(posedge clk);
        #1;
        if1.tx_valid = 1'b0;
        if1.tx_data  = 8'h00;
        wait_edge(n + 10 * B1 + 5);
        m1_en = 1'b0;
        n_cmp++; if (acc_q.size() !== 1 || acc_q[0] !== n) begin n_bad++; $display("FAIL rmf_accept: %0d accepts, want 1 at %0d", acc_q.size(), n); end
        n_cmp++; if (m1_bad_tone !== 0) begin n_bad++; $display("FAIL rmf_tone81: %0d bad cycles, want 0", m1_bad_tone); end
        n_cmp++; if (m1_bad_half !== 0) begin n_bad++; $display("FAIL rmf_half: %0d bad, len %0d at %0d, want 0", m1_bad_half, m1_bad_len, m1_bad_at); end
        n_cmp++; if (m1_busy_cnt !== 10000) begin n_bad++; $display("FAIL rmf_busy_len: %0d clocks, want 10000", m1_busy_cnt); end
    endtask

    task automatic test_param_override();
        longint n;
        fr2_n.delete(); fr2_d.delete();
        mon2_start();
        repeat (13) @(posedge clk);
        #1;
        if2.tx_data  = 8'h01;
        if2.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        if2.tx_valid = 1'b0;
        if2.tx_data  = 8'hFE;
        fr2_n.push_back(n); fr2_d.push_back(8'h01);
        wait_edge(n + 10 * B2 + 12);
        m2_en = 1'b0;
        n_cmp++; if (m2_bad_tone !== 0) begin n_bad++; $display("FAIL par_tone: %0d bad cycles, want 0", m2_bad_tone); end
        n_cmp++; if (m2_bad_busy !== 0) begin n_bad++; $display("FAIL par_busy: %0d bad cycles, want 0", m2_bad_busy); end
        n_cmp++; if (m2_bad_half !== 0) begin n_bad++; $display("FAIL par_half: %0d bad half-periods, want 0", m2_bad_half); end
        n_cmp++; if (m2_busy_cnt !== 200) begin n_bad++; $display("FAIL par_frame_len: %0d clocks, want 200", m2_busy_cnt); end
        n_cmp++; if (m2_min !== 2 || m2_max !== 5) begin n_bad++; $display("FAIL par_minmax: %0d..%0d, want 2..5", m2_min, m2_max); end
        n_cmp++; if (m2_n_half < 40) begin n_bad++; $display("FAIL par_count: %0d half-periods, want >= 40", m2_n_half); end
    endtask

    initial begin
        if1.tx_data  = 8'h00;
        if1.tx_valid = 1'b0;
        if2.tx_data  = 8'h00;
        if2.tx_valid = 1'b0;
        test_reset();
        test_idle_tone();
        test_single_frame();
        test_handshake();
        test_phase_continuity();
        test_back_to_back();
        test_reset_mid_frame();
        test_param_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsk_modulator.md
# fsk_modulator

Binary FSK transmitter, the transmit-side counterpart of the FSK receive chain. It accepts one byte at a time over a valid/ready handshake and frames it as start bit, 8 data bits LSB first, then stop bit. Each bit is sent as a phase-continuous square wave: the mark tone for '1' and the space tone for '0'. Between frames the line idles at the mark tone. Tone half-periods default to 98/99 clocks, matching the receiver's divider range.

## Interface
- HALF_MARK, 98: clocks per half-period of mark tone ('1'); must be ≥ 2
- HALF_SPACE, 99: clocks per half-period of space tone ('0'); must be ≥ 2
- BAUD_DIV, 1000: clocks per transmitted bit; must be ≥ 2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- tx_data  in  8  byte to transmit, sampled on accept
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  block can accept a byte (high only in IDLE)
- fsk_out  out  1  modulated square wave
- tone_sel  out  1  current tone: 1 = mark, 0 = space
- busy  out  1  frame in progress (state ≠ IDLE)

## Operation
- Reset values (asynchronous): state IDLE, tone_cnt 0, baud_cnt 0, bit_idx 0, shift register 0, fsk_out 0, tone_sel 1, tx_ready 1, busy 0.
- FSM states are IDLE → START → DATA → STOP → IDLE.
  - IDLE: tone_sel = 1. Accept occurs when tx_valid && tx_ready at a clock edge. On accept, load the shift register, clear baud_cnt and bit_idx, and go to START.
  - START: tone_sel = 0 for BAUD_DIV clocks, then go to DATA.
  - DATA: tone_sel = shift[0]. Every BAUD_DIV clocks, shift right and increment bit_idx. After the bit_idx = 7 period ends, go to STOP.
  - STOP: tone_sel = 1 for BAUD_DIV clocks, then go to IDLE.
- baud_cnt counts 0..BAUD_DIV−1. The bit period ends on the cycle where baud_cnt = BAUD_DIV−1; baud_cnt then wraps to 0.
- Tone generator: 32-bit tone_cnt and lim = tone_sel ? HALF_MARK : HALF_SPACE.
  - If tone_cnt ≥ lim−1, toggle fsk_out and clear tone_cnt.
  - Otherwise, increment tone_cnt.
  - The generator runs continuously in every state, including IDLE.
- Phase continuity: tone_cnt is never cleared on a tone change, only on a toggle or reset.
  - At a tone switch, the half-period in progress lies in [min(HALF_MARK, HALF_SPACE), max(HALF_MARK, HALF_SPACE)] clocks.
  - There are no runt pulses and no double toggles.
- Handshake rules:
  - tx_ready = (state == IDLE), decoded directly from the state register.
  - tx_valid is ignored while busy. No buffering and no overrun flag.
  - tx_data must be stable only in the accept cycle.
- All counters are 32-bit unsigned. Parameter values must fit in 32 bits; no other wrap is possible.

## Timing
- Accept at edge N: busy = 1, tx_ready = 0, tone_sel = 0 visible after edge N.
- Frame length: exactly 10·BAUD_DIV clocks from the accept edge to the return to IDLE (busy falls at edge N + 10·BAUD_DIV).
- Bit k (k = 0 for the start bit) occupies the cycles after edges N + k·BAUD_DIV through N + (k+1)·BAUD_DIV.
- Back-to-back frames: the earliest next accept is edge N + 10·BAUD_DIV + 1 (at least one IDLE cycle at mark tone).
- A tone change affects the toggle comparison in the same cycle tone_sel changes. fsk_out reflects it from the next edge.
- Reset asserted mid-frame: all outputs take their reset values immediately and asynchronously, and the frame is abandoned. After release, the block is IDLE and ready on the first edge.
- tx_valid asserted in the same cycle as reset release: not accepted until the first edge with rst low.

## Test plan
- Idle tone: reset, hold tx_valid = 0 for 2000 clocks → fsk_out toggles every 98 clocks (period 196), tone_sel = 1, busy = 0, tx_ready = 1.
- Single frame: send 0xA5 → tone_sel sequence per 1000-clock bit is 0,1,0,1,0,0,1,0,1,1. Space half-periods measure 99, mark half-periods measure 98. busy is high for exactly 10000 clocks.
- Handshake: hold tx_valid = 1 with tx_data = 0x00 then 0xFF continuously → exactly one accept per 10001 clocks. tx_ready is low throughout each frame, and data changes during the frame are not transmitted.
- Phase continuity: send 0x55 → no fsk_out pulse shorter than 98 or longer than 99 clocks anywhere, including at every bit boundary.
- Reset mid-frame: assert rst during data bit 3 of 0x3C → fsk_out = 0, tone_sel = 1, busy = 0, tx_ready = 1 without waiting for a clock. A following 0x81 frame is transmitted correctly from its start bit.
- Parameter override: HALF_MARK = 2, HALF_SPACE = 5, BAUD_DIV = 20, send 0x01 → mark half-period 2, space half-period 5, frame length 200 clocks.
